// File: rtl/bgr_pkg.sv
// Shared types, default timing constants and sizing helpers for the bandgap start-up sequencer.
package bgr_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KICK   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        FAULT  = 3'd4
    } bgr_state_e;

    localparam int unsigned DEF_PULSE_CYCLES  = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 1024;
    localparam int unsigned DEF_DROP_CYCLES   = 8;
    localparam int unsigned DEF_MAX_RETRIES   = 3;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bgr_startup_seq_if.sv
// Control/status bundle between the sequencer and the bandgap top / system controller.
interface bgr_startup_seq_if
    import bgr_pkg::*;
#(
    parameter int unsigned FC_W = cnt_w(DEF_MAX_RETRIES)
);
    logic            en;
    logic            vbg_ok;
    logic            porst;
    logic            ready;
    logic            fault;
    logic [FC_W-1:0] fail_cnt;

    // Controller / analog side: supplies enable and comparator flag.
    modport master (
        output en,
        output vbg_ok,
        input  porst,
        input  ready,
        input  fault,
        input  fail_cnt
    );

    // Sequencer side.
    modport slave (
        input  en,
        input  vbg_ok,
        output porst,
        output ready,
        output fault,
        output fail_cnt
    );
endinterface

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous comparator flag; resets to 0.
module bgr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Double-register the async input into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/bgr_startup_seq.sv
// Bandgap start-up kick, settle check, dropout supervision and bounded retry sequencer.
module bgr_startup_seq
    import bgr_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned DROP_CYCLES   = DEF_DROP_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic               clk,
    input  logic               rst,
    bgr_startup_seq_if.slave   bus
);
    localparam int unsigned PH_W = cnt_w(max2(PULSE_CYCLES, SETTLE_CYCLES));
    localparam int unsigned DR_W = cnt_w(DROP_CYCLES);
    localparam int unsigned FC_W = cnt_w(MAX_RETRIES);

    bgr_state_e      r_state;
    bgr_state_e      w_state_nxt;
    logic [PH_W-1:0] r_ph;
    logic [PH_W-1:0] w_ph_nxt;
    logic [DR_W-1:0] r_drop;
    logic [DR_W-1:0] w_drop_nxt;
    logic [FC_W-1:0] r_fail;
    logic [FC_W-1:0] w_fail_nxt;
    logic            r_porst;
    logic            w_porst_nxt;
    logic            r_ready;
    logic            w_ready_nxt;
    logic            r_fault;
    logic            w_fault_nxt;
    logic            w_fail_event;
    logic            w_ok_s;

    bgr_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.vbg_ok),
        .o_q (w_ok_s)
    );

    // State, counters and registered outputs; reset drops porst asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_drop  <= '0;
            r_fail  <= '0;
            r_porst <= 1'b0;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_drop  <= w_drop_nxt;
            r_fail  <= w_fail_nxt;
            r_porst <= w_porst_nxt;
            r_ready <= w_ready_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Next-state, counter and output decode; en=0 overrides every other decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_ph_nxt     = r_ph;
        w_drop_nxt   = r_drop;
        w_fail_nxt   = r_fail;
        w_porst_nxt  = r_porst;
        w_ready_nxt  = r_ready;
        w_fault_nxt  = r_fault;
        w_fail_event = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_porst_nxt = 1'b0;
                w_ready_nxt = 1'b0;
                w_fault_nxt = 1'b0;
                if (bus.en) begin
                    w_state_nxt = KICK;
                    w_ph_nxt    = '0;
                    w_porst_nxt = 1'b1;
                end
            end
            KICK: begin
                if (r_ph == PH_W'(PULSE_CYCLES - 1)) begin
                    w_state_nxt = SETTLE;
                    w_ph_nxt    = '0;
                    w_porst_nxt = 1'b0;
                end else begin
                    w_ph_nxt = r_ph + PH_W'(1);
                end
            end
            SETTLE: begin
                if (r_ph == PH_W'(SETTLE_CYCLES - 1)) begin
                    w_ph_nxt = '0;
                    if (w_ok_s) begin
                        w_state_nxt = RUN;
                        w_ready_nxt = 1'b1;
                        w_drop_nxt  = '0;
                    end else begin
                        w_fail_event = 1'b1;
                    end
                end else begin
                    w_ph_nxt = r_ph + PH_W'(1);
                end
            end
            RUN: begin
                if (w_ok_s) begin
                    w_drop_nxt = '0;
                end else if (r_drop == DR_W'(DROP_CYCLES - 1)) begin
                    w_fail_event = 1'b1;
                end else begin
                    w_drop_nxt = r_drop + DR_W'(1);
                end
            end
            FAULT: begin
                w_porst_nxt = 1'b0;
                w_ready_nxt = 1'b0;
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Failure: count it, then either re-kick or give up.
        if (w_fail_event) begin
            w_ph_nxt    = '0;
            w_drop_nxt  = '0;
            w_ready_nxt = 1'b0;
            if (r_fail >= FC_W'(MAX_RETRIES - 1)) begin
                w_fail_nxt  = FC_W'(MAX_RETRIES);
                w_state_nxt = FAULT;
                w_fault_nxt = 1'b1;
                w_porst_nxt = 1'b0;
            end else begin
                w_fail_nxt  = r_fail + FC_W'(1);
                w_state_nxt = KICK;
                w_porst_nxt = 1'b1;
            end
        end

        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_ph_nxt    = '0;
            w_drop_nxt  = '0;
            w_fail_nxt  = '0;
            w_porst_nxt = 1'b0;
            w_ready_nxt = 1'b0;
            w_fault_nxt = 1'b0;
        end
    end

    assign bus.porst    = r_porst;
    assign bus.ready    = r_ready;
    assign bus.fault    = r_fault;
    assign bus.fail_cnt = r_fail;
endmodule

// File: tb/tb_bgr_startup_seq.sv
// Directed, table-driven bench for bgr_startup_seq with small timing parameters.
module tb_bgr_startup_seq;

    localparam int unsigned P  = 4;
    localparam int unsigned S  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned M  = 3;
    localparam int unsigned FW = 2;

    typedef struct {
        string       name;
        logic        en;
        logic        vbg;
        int          n;
        logic        porst;
        logic        ready;
        logic        fault;
        logic [1:0]  fcnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    vec_t vecs[$];

    bgr_startup_seq_if #(.FC_W(FW)) bus ();

    bgr_startup_seq #(
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S),
        .DROP_CYCLES   (D),
        .MAX_RETRIES   (M)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic en, logic vbg, int n,
                                logic p, logic r, logic f, logic [1:0] c);
        vec_t v;
        v.name = nm; v.en = en; v.vbg = vbg; v.n = n;
        v.porst = p; v.ready = r; v.fault = f; v.fcnt = c;
        return v;
    endfunction

    task automatic check(input string nm, input logic p, input logic r,
                         input logic f, input logic [1:0] c);
        logic [4:0] act;
        logic [4:0] exp;
        act = {bus.porst, bus.ready, bus.fault, bus.fail_cnt};
        exp = {p, r, f, c};
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t {porst,ready,fault,fail_cnt} got %b expected %b",
                     nm, $time, act, exp);
        end
    endtask

    // Drive one row for v.n edges, checking outputs after every edge.
    task automatic apply(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            bus.en     = v.en;
            bus.vbg_ok = v.vbg;
            @(posedge clk);
            @(negedge clk);
            check(v.name, v.porst, v.ready, v.fault, v.fcnt);
        end
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.vbg_ok = 1'b1;
        @(negedge clk);
        check("reset_values", 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean start, then RUN glitch filter and dropout retry.
        vecs.push_back(mk("idle",          0, 1,  2, 0, 0, 0, 0));
        vecs.push_back(mk("clean_e0",      1, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk("clean_kick",    1, 1,  3, 1, 0, 0, 0));
        vecs.push_back(mk("clean_e4",      1, 1,  1, 0, 0, 0, 0));
        vecs.push_back(mk("clean_settle",  1, 1, 15, 0, 0, 0, 0));
        vecs.push_back(mk("clean_e20",     1, 1,  1, 0, 1, 0, 0));
        vecs.push_back(mk("clean_run",     1, 1,  5, 0, 1, 0, 0));
        vecs.push_back(mk("glitch3_low",   1, 0,  3, 0, 1, 0, 0));
        vecs.push_back(mk("glitch3_rec",   1, 1,  5, 0, 1, 0, 0));
        vecs.push_back(mk("drop4_low",     1, 0,  4, 0, 1, 0, 0));
        vecs.push_back(mk("drop4_third",   1, 1,  1, 0, 1, 0, 0));
        vecs.push_back(mk("drop4_edge",    1, 1,  1, 1, 0, 0, 1));
        vecs.push_back(mk("drop_kick",     1, 1,  3, 1, 0, 0, 1));
        vecs.push_back(mk("drop_e4",       1, 1,  1, 0, 0, 0, 1));
        vecs.push_back(mk("drop_settle",   1, 1, 15, 0, 0, 0, 1));
        vecs.push_back(mk("drop_ready",    1, 1,  1, 0, 1, 0, 1));
        vecs.push_back(mk("en_off",        0, 1,  1, 0, 0, 0, 0));
        vecs.push_back(mk("en_off_hold",   0, 0,  3, 0, 0, 0, 0));
        // Late core: first check fails, passes on the second window.
        vecs.push_back(mk("late_e0",       1, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk("late_kick",     1, 0,  3, 1, 0, 0, 0));
        vecs.push_back(mk("late_e4",       1, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk("late_settle1",  1, 0, 15, 0, 0, 0, 0));
        vecs.push_back(mk("late_e20",      1, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk("late_kick2",    1, 0,  3, 1, 0, 0, 1));
        vecs.push_back(mk("late_e24",      1, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk("late_settle2",  1, 1, 15, 0, 0, 0, 1));
        vecs.push_back(mk("late_e40",      1, 1,  1, 0, 1, 0, 1));
        vecs.push_back(mk("late_off",      0, 0,  3, 0, 0, 0, 0));
        // Dead core: three failures then sticky fault until en drops.
        vecs.push_back(mk("dead_e0",       1, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk("dead_kick1",    1, 0,  3, 1, 0, 0, 0));
        vecs.push_back(mk("dead_e4",       1, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk("dead_settle1",  1, 0, 15, 0, 0, 0, 0));
        vecs.push_back(mk("dead_e20",      1, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk("dead_kick2",    1, 0,  3, 1, 0, 0, 1));
        vecs.push_back(mk("dead_e24",      1, 0,  1, 0, 0, 0, 1));
        vecs.push_back(mk("dead_settle2",  1, 0, 15, 0, 0, 0, 1));
        vecs.push_back(mk("dead_e40",      1, 0,  1, 1, 0, 0, 2));
        vecs.push_back(mk("dead_kick3",    1, 0,  3, 1, 0, 0, 2));
        vecs.push_back(mk("dead_e44",      1, 0,  1, 0, 0, 0, 2));
        vecs.push_back(mk("dead_settle3",  1, 0, 15, 0, 0, 0, 2));
        vecs.push_back(mk("dead_e60",      1, 0,  1, 0, 0, 1, 3));
        vecs.push_back(mk("dead_fault",    1, 0,  5, 0, 0, 1, 3));
        vecs.push_back(mk("dead_en_off",   0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk("dead_idle",     0, 1,  3, 0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Disable priority: en drops on the edge that would have passed SETTLE.
        apply(mk("dis_e0",     1, 1,  1, 1, 0, 0, 0));
        apply(mk("dis_kick",   1, 1,  3, 1, 0, 0, 0));
        apply(mk("dis_e4",     1, 1,  1, 0, 0, 0, 0));
        apply(mk("dis_settle", 1, 1, 15, 0, 0, 0, 0));
        apply(mk("dis_e20",    0, 1,  1, 0, 0, 0, 0));
        apply(mk("dis_idle",   0, 1,  4, 0, 0, 0, 0));

        // Async reset mid-KICK: porst must drop without a clock edge.
        apply(mk("rk_e0",      1, 1,  2, 1, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        check("rk_async_drop", 1'b0, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        check("rk_held", 1'b0, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        apply(mk("rk_restart", 1, 1,  1, 1, 0, 0, 0));
        apply(mk("rk_kick",    1, 1,  3, 1, 0, 0, 0));
        apply(mk("rk_e4",      1, 1,  1, 0, 0, 0, 0));
        apply(mk("rk_settle",  1, 1, 15, 0, 0, 0, 0));
        apply(mk("rk_ready",   1, 1,  1, 0, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
